// File: rtl/switch_read_arbiter.sv
// Round-robin arbiter sharing the switch read port between the CPU/memorio path (req0)
// and the debug/UART snooper (req1); one access in flight, data returned with a 1-cycle ack.
module switch_read_arbiter #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned WAIT_CYC = 0
) (
    input  logic              swarbclk,
    input  logic              swarbrst_n,
    input  logic              req0,
    input  logic [1:0]        addr0,
    input  logic              req1,
    input  logic [1:0]        addr1,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              gnt_id,
    output logic              switchcs,
    output logic              switchread,
    output logic [1:0]        switchaddr,
    input  logic [DATA_W-1:0] switchrdata
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              last, last_nx;
    logic              win;
    logic              ack0_nx, ack1_nx, busy_nx, gnt_nx, cs_nx, rd_nx;
    logic [1:0]        addr_nx;
    logic [DATA_W-1:0] rdata0_nx, rdata1_nx;

    always_ff @(posedge swarbclk or negedge swarbrst_n) begin
        if (!swarbrst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            last       <= 1'b1;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            busy       <= 1'b0;
            gnt_id     <= 1'b0;
            switchcs   <= 1'b0;
            switchread <= 1'b0;
            switchaddr <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            last       <= last_nx;
            ack0       <= ack0_nx;
            ack1       <= ack1_nx;
            busy       <= busy_nx;
            gnt_id     <= gnt_nx;
            switchcs   <= cs_nx;
            switchread <= rd_nx;
            switchaddr <= addr_nx;
            rdata0     <= rdata0_nx;
            rdata1     <= rdata1_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        last_nx   = last;
        ack0_nx   = 1'b0;
        ack1_nx   = 1'b0;
        busy_nx   = busy;
        gnt_nx    = gnt_id;
        cs_nx     = switchcs;
        rd_nx     = switchread;
        addr_nx   = switchaddr;
        rdata0_nx = rdata0;
        rdata1_nx = rdata1;
        // On contention the requester not served last wins; otherwise the lone requester.
        win       = (req0 && req1) ? ~last : req1;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_nx   = win;
                    addr_nx  = win ? addr1 : addr0;
                    cs_nx    = 1'b1;
                    rd_nx    = 1'b1;
                    busy_nx  = 1'b1;
                    cnt_nx   = WAIT_INIT;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - 4'd1;
                end else begin
                    if (gnt_id) begin
                        rdata1_nx = switchrdata;
                        ack1_nx   = 1'b1;
                    end else begin
                        rdata0_nx = switchrdata;
                        ack0_nx   = 1'b1;
                    end
                    cs_nx    = 1'b0;
                    rd_nx    = 1'b0;
                    busy_nx  = 1'b0;
                    last_nx  = gnt_id;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_switch_read_arbiter.sv
// Scoreboard bench for switch_read_arbiter: WAIT_CYC=0 instance driven by requester tasks,
// plus a WAIT_CYC=3 instance for strobe stretching and address hold.
module tb_switch_read_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [1:0]  addr0 = '0, addr1 = '0;
    logic        ack0, ack1, busy, gnt_id, switchcs, switchread;
    logic [15:0] rdata0, rdata1;
    logic [1:0]  switchaddr;
    logic [15:0] switchrdata = '0;

    logic        w_req0 = 1'b0;
    logic [1:0]  w_addr0 = '0;
    logic        w_ack0, w_ack1, w_busy, w_gnt, w_cs, w_rd;
    logic [15:0] w_rdata0, w_rdata1;
    logic [1:0]  w_addr;
    logic [15:0] w_srdata = '0;

    logic [15:0] mem [4];
    initial begin
        mem[0] = 16'hA5C3;
        mem[1] = 16'h1111;
        mem[2] = 16'h0005;
        mem[3] = 16'h3333;
    end

    always #5 clk = ~clk;

    switch_read_arbiter #(.DATA_W(16), .WAIT_CYC(0)) dut (
        .swarbclk(clk), .swarbrst_n(rst_n),
        .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
        .ack0(ack0), .rdata0(rdata0), .ack1(ack1), .rdata1(rdata1),
        .busy(busy), .gnt_id(gnt_id),
        .switchcs(switchcs), .switchread(switchread), .switchaddr(switchaddr),
        .switchrdata(switchrdata)
    );

    switch_read_arbiter #(.DATA_W(16), .WAIT_CYC(3)) dut3 (
        .swarbclk(clk), .swarbrst_n(rst_n),
        .req0(w_req0), .addr0(w_addr0), .req1(1'b0), .addr1(2'b00),
        .ack0(w_ack0), .rdata0(w_rdata0), .ack1(w_ack1), .rdata1(w_rdata1),
        .busy(w_busy), .gnt_id(w_gnt),
        .switchcs(w_cs), .switchread(w_rd), .switchaddr(w_addr),
        .switchrdata(w_srdata)
    );

    // Switch block models: sample address on the falling edge while strobed, hold data otherwise.
    always @(negedge clk) begin
        if (switchcs && switchread) switchrdata <= mem[switchaddr];
        if (w_cs && w_rd)           w_srdata    <= mem[w_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        bit          id;
        logic [15:0] data;
    } exp_t;
    exp_t        sbq[$];
    logic [15:0] exp_r0 = '0, exp_r1 = '0;
    int          nacks = 0;
    int          prev_ack = -1;
    bit          spacing_on = 1'b0;

    task automatic push_exp(input bit id, input logic [1:0] a);
        exp_t e;
        e.id   = id;
        e.data = mem[a];
        sbq.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (ack0 || ack1)) begin
                nacks++;
                check_val("ack_overlap", {31'd0, ack0 & ack1}, 32'd0);
                if (sbq.size() == 0) begin
                    check_val("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check_val("ack_id", {31'd0, ack1}, {31'd0, e.id});
                    check_val("gnt_id", {31'd0, gnt_id}, {31'd0, e.id});
                    if (e.id) exp_r1 = e.data;
                    else      exp_r0 = e.data;
                    check_val("rdata0", {16'd0, rdata0}, {16'd0, exp_r0});
                    check_val("rdata1", {16'd0, rdata1}, {16'd0, exp_r1});
                end
                if (spacing_on && prev_ack >= 0)
                    check_val("ack_spacing", cyc - prev_ack, 32'd2);
                prev_ack = cyc;
            end
        end
    end

    task automatic wait_ack(input bit id);
        bit ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (id ? ack1 : ack0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_val(id ? "ack1_timeout" : "ack0_timeout", 32'd0, 32'd1);
    endtask

    task automatic req_loop(input bit id, input int n, input logic [1:0] a);
        for (int i = 0; i < n; i++) begin
            if (id) begin req1 = 1'b1; addr1 = a; end
            else    begin req0 = 1'b1; addr0 = a; end
            wait_ack(id);
            if (id) req1 = 1'b0;
            else    req0 = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int base;
        repeat (3) @(negedge clk);
        check_val("rst_outs", {ack0, ack1, busy, gnt_id, switchcs, switchread, switchaddr}, 32'd0);
        check_val("rst_rdata", {rdata0, rdata1}, 32'd0);

        // Reset mid-access aborts it; a fresh access follows after release.
        rst_n = 1'b1;
        req0 = 1'b1; addr0 = 2'b01;
        @(posedge clk); #1;
        check_val("pre_abort_cs", {31'd0, switchcs}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("abort_strobes", {28'd0, switchcs, switchread, busy, ack0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(1'b0, 2'b01);
        @(posedge clk); #1;
        check_val("rearm_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        check_val("rearm_ack0_T1", {31'd0, ack0}, 32'd1);
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);

        // Single read, one strobe cycle then a one-cycle ack.
        req0 = 1'b1; addr0 = 2'b00;
        push_exp(1'b0, 2'b00);
        @(posedge clk); #1;
        check_val("single_strobe", {29'd0, switchcs, switchread, switchaddr == 2'b00}, 32'd7);
        @(posedge clk); #1;
        check_val("single_end", {30'd0, switchcs, ack0}, 32'd1);
        check_val("single_rdata0", {16'd0, rdata0}, 32'hA5C3);
        @(negedge clk);
        req0 = 1'b0;
        @(posedge clk); #1;
        check_val("single_ack_pulse", {30'd0, ack0, busy}, 32'd0);
        @(negedge clk);

        // Upper address bits from requester 1.
        req1 = 1'b1; addr1 = 2'b10;
        push_exp(1'b1, 2'b10);
        @(posedge clk); #1;
        check_val("upper_addr", {30'd0, switchaddr}, 32'd2);
        check_val("upper_gnt", {31'd0, gnt_id}, 32'd1);
        wait_ack(1'b1);
        req1 = 1'b0;
        check_val("upper_rdata1", {16'd0, rdata1}, 32'h0005);
        @(negedge clk);

        // Contention: both held, grants must alternate starting with requester 0.
        for (int i = 0; i < 8; i++) push_exp(i[0], i[0] ? 2'b11 : 2'b01);
        prev_ack   = -1;
        spacing_on = 1'b1;
        base       = nacks;
        fork
            req_loop(1'b0, 4, 2'b01);
            req_loop(1'b1, 4, 2'b11);
        join
        spacing_on = 1'b0;
        check_val("contention_acks", nacks - base, 32'd8);
        check_val("contention_drained", sbq.size(), 32'd0);
        @(negedge clk);

        // Early drop: a one-cycle request still completes, exactly once.
        base = nacks;
        req1 = 1'b1; addr1 = 2'b11;
        push_exp(1'b1, 2'b11);
        @(posedge clk); #1;
        req1 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_val("early_drop_acks", nacks - base, 32'd1);
        check_val("early_drop_idle", {31'd0, busy}, 32'd0);
        check_val("early_drop_drained", sbq.size(), 32'd0);
        @(negedge clk);

        // WAIT_CYC=3: four strobe cycles, address frozen at grant, ack on the fifth.
        w_req0 = 1'b1; w_addr0 = 2'b01;
        @(posedge clk); #1;
        w_req0 = 1'b0; w_addr0 = 2'b10;
        check_val("w3_strobe0", {29'd0, w_cs, w_rd, w_ack0}, 32'd6);
        check_val("w3_addr0", {30'd0, w_addr}, 32'd1);
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            check_val("w3_strobe_hold", {29'd0, w_cs, w_rd, w_ack0}, 32'd6);
            check_val("w3_addr_hold", {30'd0, w_addr}, 32'd1);
        end
        @(posedge clk); #1;
        check_val("w3_ack", {29'd0, w_cs, w_busy, w_ack0}, 32'd1);
        check_val("w3_rdata0", {16'd0, w_rdata0}, 32'h1111);
        check_val("w3_rdata1", {16'd0, w_rdata1}, 32'd0);
        @(posedge clk); #1;
        check_val("w3_ack_pulse", {30'd0, w_ack0, w_busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_val("w3_no_regrant", {30'd0, w_busy, w_cs}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
